// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the fetch stage: FSM state encoding, NOP word, default reset PC.
package fetch_unit_pkg;

    typedef enum logic [2:0] {
        FETCH_IDLE  = 3'd0,
        FETCH_REQ   = 3'd1,
        FETCH_WAIT  = 3'd2,
        FETCH_HOLD  = 3'd3,
        FETCH_DRAIN = 3'd4
    } fetch_state_e;

    localparam logic [31:0] FETCH_NOP      = 32'h0000_0013;
    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response channel plus the decode-side valid/stall handshake.
interface fetch_unit_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        stall;

    modport master (
        output imem_req_valid, imem_addr, inst_valid, inst, inst_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, stall
    );

    modport slave (
        input  imem_req_valid, imem_addr, inst_valid, inst, inst_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, stall
    );

endinterface

// File: rtl/fetch_unit_rsp_buf.sv
// fetch_rsp_buf: one-entry inst/inst_pc/valid holding register; kill beats clear beats load.
module fetch_rsp_buf #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clear,
    input  logic        kill,
    input  logic [31:0] load_inst,
    input  logic [31:0] load_pc,
    output logic        valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid   <= 1'b0;
            inst    <= NOP_INST;
            inst_pc <= RESET_PC;
        end else if (kill) begin
            valid <= 1'b0;
            inst  <= NOP_INST;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid   <= 1'b1;
            inst    <= load_inst;
            inst_pc <= load_pc;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: holds the architectural PC and keeps one imem read outstanding.
// Defining FETCH_MISALIGN_CHK_EN adds the fetch_misalign output and suppresses requests for unaligned PCs.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
    parameter logic [31:0] NOP_INST = FETCH_NOP
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  next_pc,
    input  logic         redirect,
    output logic [31:0]  pc,
`ifdef FETCH_MISALIGN_CHK_EN
    output logic         fetch_misalign,
`endif
    fetch_unit_if.master bus
);

    // state | meaning
    // IDLE  | one cycle after reset before the first request
    // REQ   | request presented until accepted (or unaligned pc trapped)
    // WAIT  | request accepted, waiting for its response
    // HOLD  | inst valid to decode, waiting for !stall
    // DRAIN | killed request still in flight; its response is discarded

`ifdef FETCH_MISALIGN_CHK_EN
    localparam bit MISALIGN_CHK = 1'b1;
`else
    localparam bit MISALIGN_CHK = 1'b0;
`endif

    fetch_state_e state;
    logic         req_valid;
    logic [31:0]  addr;
    logic [31:0]  pc_d;
    logic         pc_d_misaligned;
    logic         redirect_live;
    logic         buf_load;
    logic         buf_clear;
    logic         buf_kill;
    logic [31:0]  buf_data;
    logic         buf_valid;
    logic [31:0]  buf_inst;
    logic [31:0]  buf_pc;

    assign redirect_live   = redirect && (state != FETCH_IDLE);
    assign pc_d_misaligned = MISALIGN_CHK && (pc_d[1:0] != 2'b00);

    always_comb begin
        pc_d = pc;
        if (redirect_live || (state == FETCH_HOLD && !bus.stall)) begin
            pc_d = next_pc;
        end
    end

    // Request valid/addr are registered; every entry into REQ loads them from pc_d.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= FETCH_IDLE;
            pc        <= RESET_PC;
            req_valid <= 1'b0;
            addr      <= RESET_PC;
        end else begin
            pc <= pc_d;
            unique case (state)
                FETCH_IDLE: begin
                    state     <= FETCH_REQ;
                    req_valid <= !pc_d_misaligned;
                    addr      <= pc_d;
                end
                FETCH_REQ: begin
                    if (req_valid && bus.imem_req_ready) req_valid <= 1'b0;
                    if (redirect_live && req_valid) begin
                        state <= FETCH_DRAIN;
                    end else if (redirect_live) begin
                        req_valid <= !pc_d_misaligned;
                        addr      <= pc_d;
                    end else if (!req_valid) begin
                        state <= FETCH_HOLD;
                    end else if (bus.imem_req_ready) begin
                        state <= FETCH_WAIT;
                    end
                end
                FETCH_WAIT: begin
                    if (redirect_live && !bus.imem_rsp_valid) begin
                        state <= FETCH_DRAIN;
                    end else if (redirect_live) begin
                        state     <= FETCH_REQ;
                        req_valid <= !pc_d_misaligned;
                        addr      <= pc_d;
                    end else if (bus.imem_rsp_valid) begin
                        state <= FETCH_HOLD;
                    end
                end
                FETCH_HOLD: begin
                    if (redirect_live || !bus.stall) begin
                        state     <= FETCH_REQ;
                        req_valid <= !pc_d_misaligned;
                        addr      <= pc_d;
                    end
                end
                FETCH_DRAIN: begin
                    // An unaccepted killed request must still complete before its response can be dropped.
                    if (req_valid) begin
                        if (bus.imem_req_ready) req_valid <= 1'b0;
                    end else if (bus.imem_rsp_valid) begin
                        state     <= FETCH_REQ;
                        req_valid <= !pc_d_misaligned;
                        addr      <= pc_d;
                    end
                end
                default: state <= FETCH_IDLE;
            endcase
        end
    end

    always_comb begin
        buf_load  = 1'b0;
        buf_clear = 1'b0;
        buf_kill  = 1'b0;
        buf_data  = bus.imem_rsp_data;
        if (redirect_live) begin
            buf_kill = 1'b1;
        end else begin
            unique case (state)
                FETCH_WAIT: buf_load = bus.imem_rsp_valid;
                FETCH_REQ: begin
                    if (!req_valid) begin
                        buf_load = 1'b1;
                        buf_data = NOP_INST;
                    end
                end
                FETCH_HOLD: buf_clear = !bus.stall;
                default: buf_load = 1'b0;
            endcase
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_misalign <= 1'b0;
        end else if (buf_kill || buf_clear) begin
            fetch_misalign <= 1'b0;
        end else if (state == FETCH_REQ && !req_valid) begin
            fetch_misalign <= 1'b1;
        end
    end
`endif

    fetch_rsp_buf #(
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP_INST)
    ) u_rsp_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (buf_load),
        .clear     (buf_clear),
        .kill      (buf_kill),
        .load_inst (buf_data),
        .load_pc   (pc),
        .valid     (buf_valid),
        .inst      (buf_inst),
        .inst_pc   (buf_pc)
    );

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_addr      = addr;
    assign bus.inst_valid     = buf_valid;
    assign bus.inst           = buf_inst;
    assign bus.inst_pc        = buf_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed stimulus pushes expected inst/inst_pc, a monitor pops on decode accept.
`timescale 1ns/1ps
module tb_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        redirect;
    logic        use_target;
    logic [31:0] target;
    logic [31:0] next_pc;
    logic [31:0] pc;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        fetch_misalign;
`endif

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .next_pc        (next_pc),
        .redirect       (redirect),
        .pc             (pc),
`ifdef FETCH_MISALIGN_CHK_EN
        .fetch_misalign (fetch_misalign),
`endif
        .bus            (bus)
    );

    // The bench plays pc_mux: sequential pc+4 unless a redirect target is selected.
    assign next_pc = use_target ? target : pc + 32'd4;

    int   tests = 0;
    int   failures = 0;
    int   cyc = 0;
    int   mem_delay = 2;
    int   mem_cnt = 0;
    logic [31:0] mem_addr = 32'h0;
    exp_t exp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void push_exp(input logic [31:0] p, input logic [31:0] i);
        exp_t e;
        e.pc   = p;
        e.inst = i;
        exp_q.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!bus.inst_valid && n < 20);
        check({name, "_valid_seen"}, {31'b0, bus.inst_valid}, 32'd1);
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!bus.imem_req_valid && n < 20);
        check({name, "_req_seen"}, {31'b0, bus.imem_req_valid}, 32'd1);
    endtask

    task automatic wait_rsp(input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!bus.imem_rsp_valid && n < 20);
        check({name, "_rsp_seen"}, {31'b0, bus.imem_rsp_valid}, 32'd1);
    endtask

    // Instruction memory: one response, returning addr ^ A5A5_0000, mem_delay edges after acceptance.
    initial begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        forever begin
            @(negedge clk);
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                mem_cnt  = mem_delay;
                mem_addr = bus.imem_addr;
            end
            @(posedge clk);
            #1;
            bus.imem_rsp_valid = 1'b0;
            if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    bus.imem_rsp_valid = 1'b1;
                    bus.imem_rsp_data  = mem_addr ^ 32'hA5A5_0000;
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.inst_valid && !bus.stall && !redirect) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    failures++;
                    $display("FAIL unexpected_inst: got pc %h inst %h, expected none", bus.inst_pc, bus.inst);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_inst_pc", bus.inst_pc, e.pc);
                    check("sb_inst", bus.inst, e.inst);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        rst_n              = 1'b0;
        redirect           = 1'b0;
        use_target         = 1'b0;
        target             = 32'h0;
        bus.imem_req_ready = 1'b1;
        bus.stall          = 1'b0;
        tick();
        tick();
        check("rst_pc", pc, 32'h0);
        check("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        check("rst_addr", bus.imem_addr, 32'h0);
        check("rst_inst_valid", {31'b0, bus.inst_valid}, 32'd0);
        check("rst_inst", bus.inst, NOP);
        check("rst_inst_pc", bus.inst_pc, 32'h0);

        // Sequential fetch 0,4,8,C with a ready-low window at pc 8.
        push_exp(32'h0, 32'hA5A5_0000);
        push_exp(32'h4, 32'hA5A5_0004);
        push_exp(32'h8, 32'hA5A5_0008);
        push_exp(32'hC, 32'hA5A5_000C);
        rst_n = 1'b1;
        wait_valid("seq0");
        c0 = cyc;
        wait_valid("seq4");
        check("spacing_0_4", cyc - c0, 32'd4);
        bus.imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rdy_lo_valid", {31'b0, bus.imem_req_valid}, 32'd1);
            check("rdy_lo_addr", bus.imem_addr, 32'h8);
        end
        tick();
        bus.imem_req_ready = 1'b1;
        check("rdy_c6_valid", {31'b0, bus.imem_req_valid}, 32'd1);
        check("rdy_c6_addr", bus.imem_addr, 32'h8);
        tick();
        check("rdy_accepted", {31'b0, bus.imem_req_valid}, 32'd0);
        wait_valid("seq8");
        c0 = cyc;
        wait_valid("seqC");
        check("spacing_8_C", cyc - c0, 32'd4);

        // Stall three cycles on the C instruction.
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", {31'b0, bus.inst_valid}, 32'd1);
            check("stall_inst", bus.inst, 32'hA5A5_000C);
            check("stall_inst_pc", bus.inst_pc, 32'hC);
            check("stall_pc", pc, 32'hC);
            tick();
        end
        bus.stall = 1'b0;
        mem_delay = 3;
        check("unstall_valid", {31'b0, bus.inst_valid}, 32'd1);
        tick();
        check("unstall_cleared", {31'b0, bus.inst_valid}, 32'd0);
        check("unstall_pc", pc, 32'h10);

        // Redirect to 0x40 while WAIT; stale response arrives two cycles later.
        tick();
        redirect   = 1'b1;
        use_target = 1'b1;
        target     = 32'h40;
        tick();
        redirect   = 1'b0;
        use_target = 1'b0;
        mem_delay  = 2;
        check("wait_redir_pc", pc, 32'h40);
        check("wait_redir_valid", {31'b0, bus.inst_valid}, 32'd0);
        push_exp(32'h40, 32'hA5A5_0040);
        wait_req("redir40");
        check("redir40_addr", bus.imem_addr, 32'h40);
        wait_valid("redir40");
        check("redir40_inst_pc", bus.inst_pc, 32'h40);

        // Redirect coincident with the response.
        wait_rsp("rsp_redir");
        redirect   = 1'b1;
        use_target = 1'b1;
        target     = 32'h80;
        tick();
        redirect   = 1'b0;
        use_target = 1'b0;
        check("rsp_redir_valid", {31'b0, bus.inst_valid}, 32'd0);
        check("rsp_redir_req", {31'b0, bus.imem_req_valid}, 32'd1);
        check("rsp_redir_addr", bus.imem_addr, 32'h80);
        check("rsp_redir_pc", pc, 32'h80);

        // Redirect together with stall while HOLD.
        wait_valid("hold80");
        check("hold80_inst", bus.inst, 32'hA5A5_0080);
        check("hold80_inst_pc", bus.inst_pc, 32'h80);
        bus.stall  = 1'b1;
        redirect   = 1'b1;
        use_target = 1'b1;
        target     = 32'hC0;
        tick();
        bus.stall  = 1'b0;
        redirect   = 1'b0;
        use_target = 1'b0;
        check("hold_redir_valid", {31'b0, bus.inst_valid}, 32'd0);
        check("hold_redir_inst", bus.inst, NOP);
        check("hold_redir_req", {31'b0, bus.imem_req_valid}, 32'd1);
        check("hold_redir_addr", bus.imem_addr, 32'hC0);
        push_exp(32'hC0, 32'hA5A5_00C0);
        wait_valid("fetchC0");

        // Reset during WAIT; the late response lands while REQ is unaccepted.
        mem_delay = 4;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n              = 1'b1;
        bus.imem_req_ready = 1'b0;
        check("mid_rst_pc", pc, 32'h0);
        check("mid_rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        check("mid_rst_addr", bus.imem_addr, 32'h0);
        check("mid_rst_inst_valid", {31'b0, bus.inst_valid}, 32'd0);
        check("mid_rst_inst", bus.inst, NOP);
        check("mid_rst_inst_pc", bus.inst_pc, 32'h0);
        tick();
        check("post_rst_req", {31'b0, bus.imem_req_valid}, 32'd1);
        check("post_rst_addr", bus.imem_addr, 32'h0);
        tick();
        check("late_rsp_ignored", {31'b0, bus.inst_valid}, 32'd0);
        tick();
        check("late_rsp_ignored2", {31'b0, bus.inst_valid}, 32'd0);
        mem_delay = 2;
        push_exp(32'h0, 32'hA5A5_0000);
        bus.imem_req_ready = 1'b1;
        wait_valid("post_rst_fetch");
        bus.imem_req_ready = 1'b0;
        tick();

`ifdef FETCH_MISALIGN_CHK_EN
        bus.imem_req_ready = 1'b1;
        wait_valid("pre_misalign");
        check("pre_misalign_inst_pc", bus.inst_pc, 32'h4);
        redirect           = 1'b1;
        use_target         = 1'b1;
        target             = 32'h42;
        bus.imem_req_ready = 1'b0;
        tick();
        redirect   = 1'b0;
        use_target = 1'b0;
        check("misalign_no_req", {31'b0, bus.imem_req_valid}, 32'd0);
        check("misalign_pc", pc, 32'h42);
        tick();
        bus.stall = 1'b1;
        check("misalign_valid", {31'b0, bus.inst_valid}, 32'd1);
        check("misalign_flag", {31'b0, fetch_misalign}, 32'd1);
        check("misalign_inst", bus.inst, NOP);
        check("misalign_inst_pc", bus.inst_pc, 32'h42);
        tick();
`endif

        check("sb_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
